// File: rtl/mem_pkg.sv
// mem_pkg -- shared definitions for the load path.
//
// Contents:
//   ld_type_e   : load kind encodings (reserved codes behave as LW)
//   res_err_e   : result status codes
//   lsu_state_e : load_ext_unit FSM states
//   WAIT_CNT_W  : width of the memory-wait counter (MAX_WAIT <= 255)
//   is_misaligned() : natural-alignment test used when LOAD_ALIGN_CHECK_EN is set
package mem_pkg;

  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LB  = 3'b001,
    LD_LBU = 3'b010,
    LD_LH  = 3'b011,
    LD_LHU = 3'b100
  } ld_type_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } res_err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } lsu_state_e;

  localparam int WAIT_CNT_W = 8;

  // Bytes are always aligned; halves need offset[0]==0; words (and the
  // reserved codes, which behave as words) need offset==0.
  function automatic logic is_misaligned(input logic [2:0] ld_type,
                                         input logic [1:0] offset);
    logic bad;
    case (ld_type)
      LD_LB, LD_LBU: bad = 1'b0;
      LD_LH, LD_LHU: bad = offset[0];
      default:       bad = (offset != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend -- combinational byte/half extraction and sign/zero extension.
//
// Ports:
//   word    in  32 : full word returned by memory
//   ld_type in   3 : load kind (mem_pkg::ld_type_e encoding)
//   offset  in   2 : byte address bits [1:0] of the original request
//   result  out 32 : extended load value
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  ld_type,
  input  logic [1:0]  offset,
  output logic [31:0] result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Little-endian lanes: offset 0 is the least significant byte.
  always_comb begin
    sel_byte = word[7:0];
    case (offset)
      2'd0: sel_byte = word[7:0];
      2'd1: sel_byte = word[15:8];
      2'd2: sel_byte = word[23:16];
      2'd3: sel_byte = word[31:24];
      default: sel_byte = word[7:0];
    endcase
  end

  // Only offset[1] picks the half; offset[0] is ignored here.
  assign sel_half = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = word;
    case (ld_type)
      LD_LB:   result = {{24{sel_byte[7]}}, sel_byte};
      LD_LBU:  result = {24'h000000, sel_byte};
      LD_LH:   result = {{16{sel_half[15]}}, sel_half};
      LD_LHU:  result = {16'h0000, sel_half};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_ext_unit.sv
// load_ext_unit -- single-outstanding load unit: accepts a load, issues one
// word read, extends the returned data and offers it with its tag.
//
// Parameters:
//   MAX_WAIT : REQ cycles allowed before a timeout result (1..255)
// Optional feature:
//   LOAD_ALIGN_CHECK_EN : when defined, misaligned LW/LH/LHU skip memory and
//                         return res_err=01 one cycle after acceptance.
// Ports:
//   clk, reset_n                 : clock (rising edge), async active-low reset
//   ld_valid/ld_ready            : request handshake
//   ld_type, ld_addr, ld_tag     : load kind, byte address, destination tag
//   mem_req, mem_addr            : word read request (word-aligned address)
//   mem_rvalid, mem_rdata        : read data return
//   res_valid/res_ready          : result handshake
//   res_data, res_tag, res_err   : extended result, tag, status
module load_ext_unit
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [2:0]  ld_type,
  input  logic [31:0] ld_addr,
  input  logic [4:0]  ld_tag,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_tag,
  output logic [1:0]  res_err
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

  lsu_state_e            state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [2:0]            lat_type;
  logic [1:0]            lat_off;
  logic [31:0]           ext_word;
  logic                  misaligned;

`ifdef LOAD_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(ld_type, ld_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // Handshake outputs come straight from the state register.
  assign ld_ready  = (state == ST_IDLE);
  assign mem_req   = (state == ST_REQ);
  assign res_valid = (state == ST_RESP);

  load_extend u_extend (
    .word    (mem_rdata),
    .ld_type (lat_type),
    .offset  (lat_off),
    .result  (ext_word)
  );

  // wait_cnt holds the number of REQ cycles already spent without data, so
  // the last permitted REQ cycle is the one where it equals MAX_WAIT-1.
  // mem_rvalid is checked first so data arriving on that cycle still wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      lat_type <= '0;
      lat_off  <= '0;
      mem_addr <= '0;
      res_data <= '0;
      res_tag  <= '0;
      res_err  <= ERR_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ld_valid) begin
            lat_type <= ld_type;
            lat_off  <= ld_addr[1:0];
            res_tag  <= ld_tag;
            wait_cnt <= '0;
            if (misaligned) begin
              res_data <= '0;
              res_err  <= ERR_MISALIGN;
              state    <= ST_RESP;
            end else begin
              mem_addr <= {ld_addr[31:2], 2'b00};
              state    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_rvalid) begin
            res_data <= ext_word;
            res_err  <= ERR_OK;
            state    <= ST_RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            res_data <= '0;
            res_err  <= ERR_TIMEOUT;
            state    <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_ext_unit.md
LOAD_EXT_UNIT -- requirements
Module: load_ext_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: memory-wait cycles before timeout, range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ld_valid  input  1  load request offered.
REQ-005 SHALL have port ld_ready  output  1  unit can accept a request.
REQ-006 SHALL have port ld_type  input  3  load kind, encoded LW=000, LB=001, LBU=010, LH=011, LHU=100; others reserved.
REQ-007 SHALL have port ld_addr  input  32  byte address.
REQ-008 SHALL have port ld_tag  input  5  destination register number.
REQ-009 SHALL have port mem_req  output  1  word read request to data memory.
REQ-010 SHALL have port mem_addr  output  32  word address, bits [1:0] always 0.
REQ-011 SHALL have port mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-012 SHALL have port mem_rdata  input  32  read word.
REQ-013 SHALL have port res_valid  output  1  result offered.
REQ-014 SHALL have port res_ready  input  1  consumer accepts result.
REQ-015 SHALL have port res_data  output  32  extended load result.
REQ-016 SHALL have port res_tag  output  5  tag of the result's request.
REQ-017 SHALL have port res_err  output  2  00 ok, 01 misaligned, 10 timeout.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, RESP; ld_ready = 1 only in IDLE.
REQ-019 SHALL accept a request on a clock edge with ld_valid && ld_ready; latch type, addr[1:0], tag.
REQ-020 SHALL go IDLE->REQ on an accepted legal request, driving mem_req=1 and mem_addr={addr[31:2],2'b00} from the next cycle.
REQ-021 SHALL hold mem_req and mem_addr stable in REQ until mem_rvalid=1, then capture and extend data and enter RESP.
REQ-022 SHALL count REQ cycles from 0; on count reaching MAX_WAIT without mem_rvalid, enter RESP with res_err=10, res_data=0; simultaneous mem_rvalid wins.
REQ-023 SHALL, in RESP, hold res_valid=1 and res_data/res_tag/res_err stable until res_ready=1, then enter IDLE.
REQ-024 SHALL give minimum latency: accept edge N, mem_req at N+1; rvalid at N+1 gives res_valid at N+2.
REQ-025 SHALL extract LB/LBU from byte addr[1:0] (0 = bits 7:0 ... 3 = bits 31:24) and LH/LHU from half addr[1] (0 = bits 15:0, 1 = bits 31:16).
REQ-026 SHALL sign-extend LB/LH from the selected MSB and zero-extend LBU/LHU; LW passes the word unchanged.
REQ-027 SHALL treat reserved ld_type as LW.
REQ-028 SHALL ignore mem_rvalid outside REQ.
REQ-029 SHALL keep mem_req=0 and res_valid=0 outside REQ and RESP respectively.

Reset
REQ-030 SHALL, on reset_n=0 at any time including mid-transaction, enter IDLE immediately, abandoning the transaction.
REQ-031 SHALL reset outputs to ld_ready=1, mem_req=0, mem_addr=0, res_valid=0, res_data=0, res_tag=0, res_err=00, counter=0.

Configuration
REQ-032 SHALL, with LOAD_ALIGN_CHECK_EN defined, flag LW with addr[1:0]!=0 or LH/LHU with addr[0]=1 as misaligned: no memory access, IDLE->RESP directly, res_err=01, res_data=0, res_valid at N+1.
REQ-033 SHALL, without LOAD_ALIGN_CHECK_EN, perform no alignment check: LW ignores addr[1:0], LH/LHU ignore addr[0], and res_err is never 01.

Structure
REQ-034 SHALL place ld_type encodings, res_err codes and FSM state encodings in shared package mem_pkg.
REQ-035 SHALL place extraction/extension in one combinational sub-module load_extend (inputs word, type, offset; output 32-bit result).

Verification
REQ-036 SHALL cover: LB addr 0x1003, rdata 0x80FF_1234, rvalid at N+1 -> res_data 0xFFFF_FF80 at N+2, res_err 00.
REQ-037 SHALL cover: LHU addr 0x2002, rdata 0xBEEF_0001 -> res_data 0x0000_BEEF; LH same -> 0xFFFF_BEEF.
REQ-038 SHALL cover: LW with rvalid held low 255 cycles -> res_err 10, res_data 0, mem_req drops.
REQ-039 SHALL cover: res_ready low 5 cycles after res_valid -> outputs stable, ld_ready 0 until handshake.
REQ-040 SHALL cover: LW addr 0x3001 -> with LOAD_ALIGN_CHECK_EN res_err 01 and no mem_req; without it mem_addr 0x3000 and word returned.
REQ-041 SHALL cover: reset_n low during REQ -> mem_req 0 and ld_ready 1 asynchronously, and a later stray rvalid is ignored.
